hazard_ctrl: RTL

//  Producer of pipeline stall/flush control for the 5-stage RV32I core; it pairs with the EX-stage operand forwarding logic.
//  It covers the hazards forwarding cannot resolve: load-use (one bubble), data-memory wait states (freeze) and taken-branch redirects (flush).
//  It holds a small FSM for memory waits with a timeout watchdog, plus a saturating stall-cycle counter for perf monitoring.

---
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle: ID/EX/MEM hazard inputs in,
// stall/flush/hold controls and perf counter out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             ifid_use_rs1;
  logic             ifid_use_rs2;
  logic             branch_taken;
  logic             exmem_memreq;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output idex_memread, idex_rd,
    output ifid_rs1, ifid_rs2,
    output ifid_use_rs1, ifid_use_rs2,
    output branch_taken, exmem_memreq,
    output dmem_ready,
    input  pc_write, ifid_write,
    input  ifid_flush, idex_flush,
    input  pipe_hold, mem_timeout,
    input  stall_count
  );

  modport slave (
    input  idex_memread, idex_rd,
    input  ifid_rs1, ifid_rs2,
    input  ifid_use_rs1, ifid_use_rs2,
    input  branch_taken, exmem_memreq,
    input  dmem_ready,
    output pc_write, ifid_write,
    output ifid_flush, idex_flush,
    output pipe_hold, mem_timeout,
    output stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control: load-use bubble, dmem
// wait freeze with timeout watchdog, branch redirect flush.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int WW = $clog2(MEM_TIMEOUT);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WW-1:0]    wcnt;
  logic [WW-1:0]    wcnt_nx;
  logic [CNT_W-1:0] cnt;

  logic memwait;
  logic lu;
  logic rs1_hit;
  logic rs2_hit;
  logic do_hold;

  logic pc_w;
  logic ifid_w;
  logic ifid_f;
  logic idex_f;
  logic hold;

  assign memwait = hz.exmem_memreq & ~hz.dmem_ready;

  assign rs1_hit = hz.ifid_use_rs1
                 & (hz.idex_rd == hz.ifid_rs1);
  assign rs2_hit = hz.ifid_use_rs2
                 & (hz.idex_rd == hz.ifid_rs2);
  assign lu = hz.idex_memread
            & (hz.idex_rd != 5'd0)
            & (rs1_hit | rs2_hit);

  always_comb begin
    do_hold  = 1'b0;
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      S_RUN: begin
        if (memwait) begin
          do_hold  = 1'b1;
          state_nx = S_WAIT;
          wcnt_nx  = WW'(1);
        end
      end
      S_WAIT: begin
        if (hz.dmem_ready) begin
          state_nx = S_RUN;
          wcnt_nx  = '0;
        end else begin
          do_hold = 1'b1;
          wcnt_nx = wcnt + WW'(1);
          if (wcnt == WW'(MEM_TIMEOUT - 1))
            state_nx = S_ERR;
        end
      end
      S_ERR: begin
        do_hold = 1'b1;
      end
      default: begin
        state_nx = S_RUN;
        wcnt_nx  = '0;
      end
    endcase
  end

  // release cycle in MEM_WAIT falls through to branch/lu
  always_comb begin
    pc_w   = 1'b1;
    ifid_w = 1'b1;
    ifid_f = 1'b0;
    idex_f = 1'b0;
    hold   = 1'b0;
    priority case (1'b1)
      !rst_n: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        ifid_f = 1'b1;
        idex_f = 1'b1;
      end
      do_hold: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        hold   = 1'b1;
      end
      hz.branch_taken: begin
        ifid_f = 1'b1;
        idex_f = 1'b1;
      end
      lu: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_f = 1'b1;
      end
      default: begin
        pc_w   = 1'b1;
        ifid_w = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      wcnt  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (!pc_w && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign hz.pc_write    = pc_w;
  assign hz.ifid_write  = ifid_w;
  assign hz.ifid_flush  = ifid_f;
  assign hz.idex_flush  = idex_f;
  assign hz.pipe_hold   = hold;
  assign hz.mem_timeout = (state == S_ERR);
  assign hz.stall_count = cnt;

endmodule
